vga_rect_filler: RTL and testbench

// - Write-side companion to the block-mode VGA display stage.
// - Takes a rectangle-fill command (block coordinates plus a 3-bit BGR colour).
// - Writes that colour into every covered word of the 20x15 display region in dmem.
// - The display stage reads this region at BASE_ADDR + y*H_BLOCKS + x.
// - Runs in the VGA clock domain; off-loads bulk screen updates from the processor.

---
 rtl/vga_rect_filler.sv | 96 +++++++++
 tb/tb_vga_rect_filler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_filler.sv
// vga_rect_filler: fills a block rectangle of the VGA display region in dmem with one colour.
module vga_rect_filler #(
  parameter logic [11:0] BASE_ADDR  = 12'hC00,
  parameter int          H_BLOCKS   = 20,
  parameter int          V_BLOCKS   = 15,
  parameter bit          GATE_BLANK = 1'b1
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_x0,
  input  logic [3:0]  cmd_y0,
  input  logic [4:0]  cmd_x1,
  input  logic [3:0]  cmd_y1,
  input  logic [2:0]  cmd_color,
  input  logic        vis_active,
  output logic        wr_en,
  input  logic        wr_gnt,
  output logic [11:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} state_t;
  localparam logic [11:0] H12 = 12'(H_BLOCKS);
  localparam logic [4:0]  HB  = 5'(H_BLOCKS);
  localparam logic [4:0]  VB  = 5'(V_BLOCKS);
  state_t      state;
  logic [4:0]  x0, x1, x;
  logic [3:0]  y0, y1, y;
  logic [2:0]  color;
  logic [11:0] row_base, y_off;
  logic        reject, fire;
  // y0*H_BLOCKS as a sum of shifted copies of y0 over the constant's set bits
  always_comb begin
    y_off = '0;
    for (int i = 0; i < 12; i++) y_off = H12[i] ? y_off + (12'(y0) << i) : y_off;
  end
  assign reject    = (x0 > x1) || (y0 > y1) || (x1 >= HB) || ({1'b0, y1} >= VB);
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign err       = (state == CHECK) && reject;
  assign wr_en     = (state == FILL) && !(GATE_BLANK && vis_active);
  assign fire      = wr_en && wr_gnt;
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= IDLE;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      row_base <= BASE_ADDR;
      x0       <= '0;
      x1       <= '0;
      x        <= '0;
      y0       <= '0;
      y1       <= '0;
      y        <= '0;
      color    <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          x0    <= cmd_x0;
          y0    <= cmd_y0;
          x1    <= cmd_x1;
          y1    <= cmd_y1;
          color <= cmd_color;
          state <= CHECK;
        end
        CHECK: if (reject) state <= IDLE;
        else begin
          x        <= x0;
          y        <= y0;
          row_base <= BASE_ADDR + y_off;
          wr_addr  <= BASE_ADDR + y_off + 12'(x0);
          wr_data  <= {29'b0, color};
          state    <= FILL;
        end
        FILL: if (fire) begin
          if (x < x1) begin
            x       <= x + 5'd1;
            wr_addr <= wr_addr + 12'd1;
          end else if (y < y1) begin
            x        <= x0;
            y        <= y + 4'd1;
            row_base <= row_base + H12;
            wr_addr  <= row_base + H12 + 12'(x0);
          end else state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_rect_filler.sv
// tb_vga_rect_filler: scoreboard bench for vga_rect_filler with a rectangle-level reference model.
module tb_vga_rect_filler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [4:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [3:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [2:0]  cmd_color = '0;
  logic        vis_active = 1'b0, wr_en, wr_gnt = 1'b1;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err;
  typedef struct {int kind; int addr; int data;} ev_t;
  ev_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, fires = 0, last_fire = -10, f0;
  bit rand_mode = 0;
  vga_rect_filler dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .vis_active(vis_active), .wr_en(wr_en), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end
  function automatic void chk(string n, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", n, a, e);
    end
  endfunction
  // Reference: a rejected command yields one err; otherwise every covered block in row-major order, then done.
  function automatic void expect_cmd(int x0, int y0, int x1, int y1, int c);
    if (x0 > x1 || y0 > y1 || x1 >= 20 || y1 >= 15) q.push_back('{2, 0, 0});
    else begin
      for (int yy = y0; yy <= y1; yy++)
        for (int xx = x0; xx <= x1; xx++) q.push_back('{0, 'hC00 + yy * 20 + xx, c});
      q.push_back('{1, 0, 0});
    end
  endfunction
  function automatic void pop_check(int k);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr %0h, required none", k, wr_addr);
    end else begin
      e = q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == 0) begin
        chk("wr_addr", 32'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
      end
    end
  endfunction
  // Monitor: samples on the falling edge, pops the scoreboard on every DUT-visible event.
  initial begin
    logic hold = 1'b0;
    logic [11:0] hold_addr = '0;
    logic [31:0] hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold && busy) begin
          chk("stall_addr", 32'(wr_addr), 32'(hold_addr));
          chk("stall_data", int'(wr_data), int'(hold_data));
        end
        if (wr_en && wr_gnt) begin
          fires++;
          last_fire = cyc;
          hold = 1'b0;
          pop_check(0);
        end else if (wr_en) begin
          hold = 1'b1;
          hold_addr = wr_addr;
          hold_data = wr_data;
        end
        if (!busy) hold = 1'b0;
        if (done) begin
          pop_check(1);
          chk("done_latency", cyc, last_fire + 1);
        end
        if (err) pop_check(2);
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      wr_gnt = 1'($urandom_range(0, 1));
      vis_active = ($urandom % 4) == 0;
    end
  end
  task automatic issue(int x0, int y0, int x1, int y1, int c);
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: cmd_ready got 0 required 1");
    end else begin
      cmd_x0 = 5'(x0);
      cmd_y0 = 4'(y0);
      cmd_x1 = 5'(x1);
      cmd_y1 = 4'(y1);
      cmd_color = 3'(c);
      expect_cmd(x0, y0, x1, y1, c);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idle_pending", q.size() + int'(busy), 0);
  endtask
  initial begin
    int x0, y0, x1, y1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 'hC00);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3, 2, 3, 2, 5);
    chk("t1_check_wr_en", 32'(wr_en), 0);
    @(posedge clk);
    #1;
    chk("t1_first_wr_en", 32'(wr_en), 1);
    chk("t1_first_addr", 32'(wr_addr), 'hC2B);
    wait_idle();
    f0 = fires;
    issue(0, 0, 19, 14, 0);
    cmd_x0 = 5'd0;
    cmd_y0 = 4'd0;
    cmd_x1 = 5'd0;
    cmd_y1 = 4'd0;
    cmd_color = 3'd3;
    cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    vis_active = 1'b1;
    #1;
    chk("t2_gate_drop", 32'(wr_en), 0);
    @(posedge clk);
    #1;
    vis_active = 1'b0;
    wait_idle();
    chk("t2_write_count", fires - f0, 300);
    issue(18, 13, 19, 14, 7);
    wait_idle();
    issue(0, 0, 20, 0, 1);
    chk("t4a_err", 32'(err), 1);
    @(posedge clk);
    #1;
    chk("t4a_busy_clear", 32'(busy), 0);
    issue(0, 5, 0, 4, 2);
    chk("t4b_err", 32'(err), 1);
    @(posedge clk);
    #1;
    chk("t4b_busy_clear", 32'(busy), 0);
    wait_idle();
    rand_mode = 1;
    f0 = fires;
    issue(2, 3, 5, 5, 6);
    wait_idle();
    rand_mode = 0;
    wr_gnt = 1'b1;
    vis_active = 1'b0;
    chk("t5_write_count", fires - f0, 12);
    f0 = fires;
    issue(0, 0, 1, 0, 4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_wr_en_async", 32'(wr_en), 0);
    chk("t6_busy_async", 32'(busy), 0);
    chk("t6_addr_async", 32'(wr_addr), 'hC00);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_writes_before_reset", fires - f0, 1);
    issue(10, 7, 11, 7, 3);
    wait_idle();
    rand_mode = 1;
    repeat (25) begin
      x0 = $urandom_range(0, 19);
      x1 = x0 + $urandom_range(0, 3);
      y0 = $urandom_range(0, 14);
      y1 = y0 + $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0 && x0 > 0) x1 = x0 - 1;
      issue(x0, y0, x1, y1, $urandom_range(0, 7));
    end
    wait_idle();
    rand_mode = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
